// File: rtl/data_memory_responder.sv
// Posted-write store buffer plus a single-outstanding load port,
// bridging the write stage onto an Avalon-MM master.
module data_memory_responder #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        address_enable,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic        data_valid,
  input  logic        read_enable,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        is_empty,
  output logic [31:0] avm_address,
  output logic [31:0] avm_writedata,
  output logic        avm_write,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE, WRITE, READ, READ_WAIT
  } state_t;

  state_t state, state_next;

  logic [31:0] fifo_addr [DEPTH];
  logic [31:0] fifo_data [DEPTH];
  logic [AW-1:0] head, tail, head_inc;
  logic [AW:0] count;
  logic push, pop;

  logic        write_next, read_next;
  logic        valid_next;
  logic [31:0] address_next, writedata_next;
  logic [31:0] rdata_next;

  assign head_inc = head + 1'b1;
  assign data_valid = reset_n && address_enable
                      && (count < FULL);
  assign push = data_valid;
  assign is_empty = !reset_n
                    || (count == '0 && state == IDLE);

  always_comb begin
    state_next = state;
    pop = 1'b0;
    write_next = avm_write;
    read_next = avm_read;
    address_next = avm_address;
    writedata_next = avm_writedata;
    valid_next = 1'b0;
    rdata_next = read_data;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          state_next = WRITE;
          write_next = 1'b1;
          address_next = fifo_addr[head];
          writedata_next = fifo_data[head];
        end else if (read_enable && !read_valid) begin
          state_next = READ;
          read_next = 1'b1;
          address_next = read_address;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          pop = 1'b1;
          // A lone entry being refilled this edge is still in flight.
          if (count > (AW+1)'(1)) begin
            address_next = fifo_addr[head_inc];
            writedata_next = fifo_data[head_inc];
          end else if (push) begin
            address_next = address;
            writedata_next = data;
          end else begin
            state_next = IDLE;
            write_next = 1'b0;
          end
        end
      end
      READ: begin
        if (!avm_waitrequest) begin
          state_next = READ_WAIT;
          read_next = 1'b0;
        end
      end
      READ_WAIT: begin
        if (avm_readdatavalid) begin
          state_next = IDLE;
          valid_next = 1'b1;
          rdata_next = avm_readdata;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[tail] <= address;
      fifo_data[tail] <= data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      avm_write <= 1'b0;
      avm_read <= 1'b0;
      avm_address <= '0;
      avm_writedata <= '0;
      read_valid <= 1'b0;
      read_data <= '0;
    end else begin
      state <= state_next;
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head_inc;
      unique case ({push, pop})
        2'b10: count <= count + 1'b1;
        2'b01: count <= count - 1'b1;
        default: count <= count;
      endcase
      avm_write <= write_next;
      avm_read <= read_next;
      avm_address <= address_next;
      avm_writedata <= writedata_next;
      read_valid <= valid_next;
      read_data <= rdata_next;
    end
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed/random bench for data_memory_responder with a
// queue-based store-order model and a simple Avalon slave.
module tb_data_memory_responder;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        address_enable;
  logic [31:0] address, data;
  logic        data_valid;
  logic        read_enable;
  logic [31:0] read_address, read_data;
  logic        read_valid, is_empty;
  logic [31:0] avm_address, avm_writedata;
  logic        avm_write, avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  data_memory_responder #(.DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .address_enable(address_enable),
    .address(address), .data(data),
    .data_valid(data_valid),
    .read_enable(read_enable),
    .read_address(read_address),
    .read_data(read_data),
    .read_valid(read_valid),
    .is_empty(is_empty),
    .avm_address(avm_address),
    .avm_writedata(avm_writedata),
    .avm_write(avm_write),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  int mcount = 0;
  int wr_done = 0;
  int wr_cycles = 0;
  int reads_seen = 0;
  int rv_count = 0;
  int wait_mode = 0;
  int rd_delay = 0;
  bit rd_pending = 0;
  bit load_busy = 0;
  bit last_dv, last_dut_dv, last_empty;
  logic [31:0] ld_addr, rd_value;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic drive_wait();
    if (wait_mode == 2)
      avm_waitrequest = 1'($urandom_range(0, 1));
    else
      avm_waitrequest = (wait_mode == 1);
  endtask

  task automatic set_wait(input int m);
    wait_mode = m;
    drive_wait();
  endtask

  // One clock: observe at negedge, update model, drive after posedge.
  task automatic cycle();
    bit wr_pop, drop_re;
    logic [63:0] e;
    @(negedge clock);
    last_dv = reset_n && address_enable && (mcount < 4);
    last_dut_dv = data_valid;
    last_empty = is_empty;
    chk1("data_valid", data_valid, last_dv);
    if (avm_write) begin
      wr_cycles++;
      chk1("write_nonempty", mcount != 0, 1'b1);
      chk1("write_not_in_load", load_busy, 1'b0);
      chk1("strobes_exclusive", avm_read, 1'b0);
    end
    wr_pop = avm_write && !avm_waitrequest;
    if (wr_pop && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_addr", avm_address, e[63:32]);
      chk("wr_data", avm_writedata, e[31:0]);
      wr_done++;
    end
    if (avm_read) begin
      if (!load_busy) begin
        load_busy = 1;
        chk("load_behind_stores", mcount, 0);
      end
      if (!avm_waitrequest) begin
        chk("read_addr", avm_address, ld_addr);
        reads_seen++;
        rd_pending = 1;
        rd_delay = 1;
      end
    end
    drop_re = 0;
    if (read_valid) begin
      chk1("read_valid_expected", load_busy, 1'b1);
      chk("read_data", read_data, rd_value);
      rv_count++;
      load_busy = 0;
      drop_re = 1;
    end
    if (last_dv) exp_q.push_back({address, data});
    mcount = mcount + int'(last_dv) - int'(wr_pop);
    @(posedge clock);
    #1;
    if (drop_re) read_enable = 1'b0;
    avm_readdatavalid = 1'b0;
    if (rd_pending) begin
      if (rd_delay == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = rd_value;
        rd_pending = 0;
      end else begin
        rd_delay--;
      end
    end else if (!read_enable && !load_busy
                 && wait_mode == 2) begin
      avm_readdatavalid = ($urandom_range(0, 3) == 0);
      avm_readdata = $urandom;
    end
    drive_wait();
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [31:0] d);
    int n = 0;
    address = a;
    data = d;
    address_enable = 1'b1;
    do begin
      cycle();
      n++;
    end while (!last_dv && n < 200);
    chk1("store_accepted", last_dv, 1'b1);
    address_enable = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((mcount != 0 || load_busy) && n < 300) begin
      cycle();
      n++;
    end
    chk("drain_count", mcount, 0);
    cycle();
    chk1("is_empty", last_empty, 1'b1);
  endtask

  task automatic do_load(input logic [31:0] a,
                         input logic [31:0] v);
    int n = 0;
    int rv0 = rv_count;
    int rs0 = reads_seen;
    ld_addr = a;
    rd_value = v;
    read_address = a;
    read_enable = 1'b1;
    while (rv_count == rv0 && n < 200) begin
      cycle();
      if (load_busy) read_address = $urandom;
      n++;
    end
    chk("load_done", rv_count - rv0, 1);
    repeat (3) cycle();
    chk("load_issued_once", reads_seen - rs0, 1);
  endtask

  initial begin
    int n;
    int base;
    reset_n = 1'b0;
    address_enable = 1'b1;
    address = 32'h0;
    data = 32'h0;
    read_enable = 1'b0;
    read_address = 32'h0;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h0;
    avm_readdatavalid = 1'b0;
    ld_addr = 32'h0;
    rd_value = 32'h0;
    #2;
    chk1("rst_data_valid", data_valid, 1'b0);
    chk1("rst_is_empty", is_empty, 1'b1);
    chk1("rst_avm_write", avm_write, 1'b0);
    chk1("rst_avm_read", avm_read, 1'b0);
    chk("rst_avm_address", avm_address, 32'h0);
    chk("rst_avm_wdata", avm_writedata, 32'h0);
    chk1("rst_read_valid", read_valid, 1'b0);
    chk("rst_read_data", read_data, 32'h0);
    cycle();
    address_enable = 1'b0;
    reset_n = 1'b1;
    cycle();

    // single store, no stall
    set_wait(0);
    store(32'h100, 32'hDEADBEEF);
    chk1("single_zero_latency", last_dut_dv, 1'b1);
    drain();

    // fill under stall, fifth store held off
    set_wait(1);
    for (int i = 0; i < 4; i++) begin
      store(32'h200 + 32'(i * 4), $urandom);
      chk1("fill_accept", last_dut_dv, 1'b1);
    end
    address = 32'h210;
    data = 32'hA5A5_0005;
    address_enable = 1'b1;
    cycle();
    chk1("fifth_rejected", last_dut_dv, 1'b0);
    wr_cycles = 0;
    set_wait(0);
    store(32'h210, 32'hA5A5_0005);
    drain();
    chk("back_to_back", wr_cycles, 5);

    // load ordered behind stores
    store(32'h10, 32'h1111_0010);
    store(32'h14, 32'h1111_0014);
    do_load(32'h14, 32'h55);
    drain();

    // store while a load is pending
    ld_addr = 32'h300;
    rd_value = $urandom;
    read_address = 32'h300;
    read_enable = 1'b1;
    base = reads_seen;
    n = 0;
    while (reads_seen == base && n < 50) begin
      cycle();
      n++;
    end
    chk("load_issued", reads_seen - base, 1);
    store(32'h400, 32'hCAFE_0400);
    chk1("store_in_load", last_dut_dv, 1'b1);
    drain();
    chk("load_then_store", rv_count, 2);

    // wrap-around with random stalls and loads
    set_wait(2);
    base = wr_done;
    for (int i = 0; i < 10; i++)
      store($urandom & 32'hFFFF_FFFC, $urandom);
    drain();
    chk("wrap_writes", wr_done - base, 10);
    for (int i = 0; i < 3; i++) begin
      store($urandom & 32'hFFFC, $urandom);
      do_load($urandom & 32'hFFFC, $urandom);
      drain();
    end

    // reset in the middle of a stalled write
    set_wait(1);
    for (int i = 0; i < 3; i++)
      store(32'h500 + 32'(i * 4), $urandom);
    n = 0;
    while (!avm_write && n < 20) begin
      cycle();
      n++;
    end
    chk1("write_in_flight", avm_write, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("rst_mid_write", avm_write, 1'b0);
    chk1("rst_mid_empty", is_empty, 1'b1);
    exp_q.delete();
    mcount = 0;
    load_busy = 0;
    rd_pending = 0;
    cycle();
    reset_n = 1'b1;
    set_wait(0);
    base = wr_done;
    wr_cycles = 0;
    repeat (10) cycle();
    chk("no_writes_after_rst", wr_cycles, 0);
    chk1("empty_after_rst", last_empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
